// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion stage that
// follows the GCD engine.
package gcd_pkg;

  localparam int GCD_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int CNT_W      = $clog2(GCD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/gcd_dabble_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module gcd_dabble_digit (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Add-3 correction, purely combinational.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) adjusted = digit + 4'd3;
  end

endmodule

// File: rtl/gcd_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with
// a valid/ready handshake on both sides. Build option GCD_BCD_ZERO_BLANK_EN
// enables the leading-zero mask on the blank port; otherwise blank is 0.
module gcd_bcd_conv
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [W-1:0]            bin,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [2:0]              blank
);

  localparam int BCD_W = 4 * BCD_DIGITS;

  state_t             state;
  logic [W-1:0]       sr;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W+W-1:0] shifted;
  logic [BCD_W-1:0]   result;
  logic               last_step;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    gcd_dabble_digit u_digit (
      .digit    (acc[4*i +: 4]),
      .adjusted (adj[4*i +: 4])
    );
  end

  // One double-dabble step: corrected digits and the binary operand shift
  // left together, the MSB of the operand entering the ones digit.
  assign shifted   = {adj, sr} << 1;
  assign result    = shifted[W +: BCD_W];
  assign last_step = (state == SHIFT) && (cnt == CNT_W'(W - 1));

  // Control FSM, working registers and registered handshake outputs.
  // NOTE: every register here, including the bcd output, is cleared by the
  // asynchronous reset and updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sr       <= bin;
            acc      <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          acc <= result;
          sr  <= shifted[W-1:0];
          cnt <= cnt + 1'b1;
          if (last_step) begin
            state     <= DONE;
            bcd       <= result;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Output handshake only; a pending in_valid waits for IDLE.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_BCD_ZERO_BLANK_EN
  // Leading-zero mask captured together with bcd on entry to DONE.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      blank <= '0;
    end else if (last_step) begin
      blank <= {result[11:8] == 4'd0,
                (result[11:8] == 4'd0) && (result[7:4] == 4'd0),
                1'b0};
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_gcd_bcd_conv.sv
// Self-checking bench for gcd_bcd_conv: directed handshake/reset scenarios
// plus a full 0..255 sweep with random back-pressure, checked against a
// decimal-arithmetic reference model.
module tb_gcd_bcd_conv;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  bin;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [2:0]  blank;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_bcd_conv dut (
    .clk       (clk),
    .clr       (clr),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .blank     (blank)
  );

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
`ifdef GCD_BCD_ZERO_BLANK_EN
    int h, t;
    h = v / 100;
    t = (v / 10) % 10;
    return {h == 0, (h == 0) && (t == 0), 1'b0};
`else
    return 3'b000 & 3'(v);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present v for exactly one edge.
  task automatic accept(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    bin      = v;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  // Called right after the acceptance edge; counts edges to out_valid and
  // cycles with busy high.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (lat < 20) begin
      if (busy) bcyc++;
      if (out_valid) break;
      tick;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int v, input int lat, input int bcyc);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bcyc), 32'd8);
    check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    check({tag, "_blank"}, 32'(blank), 32'(ref_blank(v)));
  endtask

  // Stall the consumer for a while (random input noise must be ignored),
  // then complete the output handshake.
  task automatic release_out(input string tag, input int stall, input int v);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      bin      = 8'($urandom);
      tick;
    end
    in_valid = 1'b0;
    check({tag, "_held_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
    check({tag, "_held_valid"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_released"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcyc, low, v;
    logic [11:0] got0;

    // Reset with out_ready high: nothing may react.
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bin = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bcd, blank, out_valid, busy}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) clr = 1'b1;
    tick;
    check("idle_out_ready_no_effect", 32'({in_ready, out_valid, busy}), 32'b100);
    out_ready = 1'b0;

    // Scenario 1: bin=93.
    accept(8'd93);
    check("s1_in_ready_low", 32'(in_ready), 32'd0);
    wait_done(lat, bcyc);
    check_result("s1", 93, lat, bcyc);
    release_out("s1", 0, 93);

    // Scenario 2: 0 then 255 back-to-back, out_ready held high.
    out_ready = 1'b1;
    bin = 8'd0; in_valid = 1'b1;
    tick;
    bin  = 8'd255;
    low  = 0;
    got0 = 12'hfff;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) got0 = bcd;
      if (in_ready) break;
      low++;
      tick;
    end
    check("s2_zero_bcd", 32'(got0), 32'h000);
    check("s2_in_ready_low_cycles", 32'(low), 32'd9);
    tick;
    in_valid = 1'b0;
    wait_done(lat, bcyc);
    check_result("s2_255", 255, lat, bcyc);
    release_out("s2_255", 0, 255);

    // Scenario 3: stall in DONE with in_valid held and bin changing.
    accept(8'd147);
    wait_done(lat, bcyc);
    check_result("s3", 147, lat, bcyc);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bin = 8'($urandom);
      tick;
      check("s3_stall_bcd", 32'(bcd), 32'(ref_bcd(147)));
      check("s3_stall_flags", 32'({out_valid, in_ready, busy}), 32'b100);
    end
    bin = 8'd77;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("s3_handshake_only", 32'({out_valid, in_ready, busy}), 32'b010);
    tick;
    in_valid = 1'b0;
    check("s3_next_cycle_accept", 32'({in_ready, busy}), 32'b01);
    wait_done(lat, bcyc);
    check("s3_second_bcd", 32'(bcd), 32'(ref_bcd(77)));
    release_out("s3_second", 1, 77);

    // Scenario 4: reset asserted after step 4 of bin=200.
    accept(8'd200);
    repeat (4) tick;
    #2 clr = 1'b0;
    #1;
    check("s4_abort_outputs", 32'({bcd, blank, out_valid, busy}), 32'd0);
    check("s4_abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) clr = 1'b1;
    tick;
    check("s4_after_release", 32'({in_ready, out_valid, busy}), 32'b100);
    accept(8'd12);
    wait_done(lat, bcyc);
    check_result("s4_12", 12, lat, bcyc);
    release_out("s4_12", 2, 12);

    // Scenario 5: full sweep with random back-pressure.
    for (int i = 0; i < 256; i++) begin
      v = i;
      accept(8'(v));
      wait_done(lat, bcyc);
      check_result("sweep", v, lat, bcyc);
      check("sweep_hundreds_max", 32'(bcd[11:8] <= 4'd2), 32'd1);
      release_out("sweep", int'($urandom_range(0, 3)), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_bcd_conv.md
GCD_BCD_CONV -- requirements
Module: gcd_bcd_conv

Interface
REQ-001 Parameter: W, 8, binary input width; the only supported value is 8, giving DIGITS = 3.
REQ-002 Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- bin  in  W  GCD result from the gcd stage
- in_valid  in  1  bin is valid
- in_ready  out  1  block can accept bin
- bcd  out  12  {hundreds, tens, ones}, 4 bits each
- out_valid  out  1  bcd is valid
- out_ready  in  1  consumer accepts bcd
- busy  out  1  conversion in progress
- blank  out  3  leading-zero mask per digit, {h, t, o}
REQ-003 clk SHALL be the only clock; clr SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-005 In IDLE, in_ready SHALL be 1; in_ready SHALL be 0 in every other state.
REQ-006 When in_valid=1 and in_ready=1 at an edge (acceptance), the block SHALL:
- latch bin into the shift register;
- clear the BCD accumulator and the shift counter;
- enter SHIFT.
REQ-007 On each SHIFT edge, the block SHALL perform one double-dabble step:
- add 3 to each digit that is >= 5;
- then shift {bcd, bin} left by 1;
- then increment the counter.
REQ-008 After the W-th step, the block SHALL enter DONE; out_valid SHALL rise exactly W=8 edges after the acceptance edge.
REQ-009 busy SHALL be 1 only in SHIFT.
REQ-010 In DONE, out_valid SHALL be 1 and bcd and blank SHALL stay stable until out_valid=1 and out_ready=1 at an edge; that edge SHALL return the FSM to IDLE.
REQ-011 Throughput SHALL be one conversion per W+2 cycles minimum; there SHALL be no skid buffer and no overlap.
REQ-012 in_valid SHALL be ignored in SHIFT and DONE, with no acceptance and no state change.
REQ-013 If in_valid=1 and out_ready=1 in the same DONE cycle, only the output handshake SHALL complete; the input SHALL be accepted no earlier than the next cycle, in IDLE.
REQ-014 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-015 Boundary results:
- bin=0 SHALL give bcd=12'h000;
- bin=255 SHALL give bcd=12'h255;
- the hundreds digit SHALL never exceed 2.
REQ-016 bcd SHALL be driven from registers only, never combinationally from bin.

Reset
REQ-017 While clr=0, the block SHALL hold:
- state=IDLE;
- bcd=0, blank=0, out_valid=0, busy=0;
- the shift register and counter at 0.
REQ-018 in_ready SHALL be 1 immediately after clr deasserts.
REQ-019 A clr assertion mid-SHIFT or in DONE SHALL abort the conversion with no output handshake; after release, the first acceptance SHALL convert correctly.

Configuration
REQ-020 With GCD_BCD_ZERO_BLANK_EN defined, blank SHALL be registered alongside bcd on entry to DONE, with:
- blank[2] = (hundreds==0);
- blank[1] = (hundreds==0 && tens==0);
- blank[0] = 0.
REQ-021 Without GCD_BCD_ZERO_BLANK_EN, blank SHALL be constant 3'b000; the port SHALL remain present and all other behaviour SHALL be identical.

Structure
REQ-022 Package gcd_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT, DONE);
- GCD_W=8 and BCD_DIGITS=3;
- counter width $clog2(W+1).
REQ-023 Sub-module gcd_dabble_digit SHALL be a combinational 4-bit add-3-if->=5 cell, instantiated BCD_DIGITS times.
REQ-024 The gcd stage SHALL connect directly: its gcd_out drives bin, and its completion indication drives in_valid.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset then bin=8'd93, in_valid 1 cycle, out_ready=1 -> out_valid 8 edges after acceptance, bcd=12'h093, blank=3'b100 (macro on) or 3'b000 (macro off).
- bin=0, then bin=255 back-to-back with out_ready=1 -> bcd=12'h000 then 12'h255; in_ready low for 9 cycles between acceptances.
- out_ready=0 for 5 cycles in DONE with in_valid held 1 and bin changing -> bcd held at the first result, no second acceptance, in_ready=0 until 1 cycle after out_ready=1.
- clr pulsed low at step 4 of bin=200 -> all outputs 0 at once; after release, bin=12 -> bcd=12'h012.
- Sweep bin=0..255 against a reference model -> every bcd matches; busy=1 for exactly 8 cycles per conversion.
